// File: rtl/nn_pkg.sv
// Shared fixed-point defaults, types and saturation helpers for the neuron datapath.
package nn_pkg;

  localparam int unsigned NN_DATA_W    = 8;
  localparam int unsigned NN_ACC_W     = 24;
  localparam int unsigned NN_FRAC_BITS = 4;

  typedef logic signed [NN_DATA_W-1:0] data_t;
  typedef logic signed [NN_ACC_W-1:0]  acc_t;
  typedef logic signed [63:0]          wide_t;

  // Clamp a wide signed value into the range of a w-bit signed word.
  function automatic wide_t sat_clamp(input wide_t x, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w,
                                    output logic ovf);
    wide_t raw;
    wide_t res;
    raw = a + b;
    res = sat_clamp(raw, w);
    ovf = (res != raw);
    return res;
  endfunction

  function automatic wide_t narrow_sat(input wide_t x, input int unsigned w);
    return sat_clamp(x, w);
  endfunction

endpackage

// File: rtl/neuron_out_stage.sv
// Output register: fixed-point rescale, optional ReLU, narrow saturation, write strobe.
module neuron_out_stage
  import nn_pkg::*;
#(
  parameter int unsigned DATA_W    = NN_DATA_W,
  parameter int unsigned ACC_W     = NN_ACC_W,
  parameter int unsigned FRAC_BITS = NN_FRAC_BITS,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    cap,
  input  logic signed [ACC_W-1:0] cap_sum,
  input  logic [ADDR_W-1:0]       cap_addr,
  input  logic                    relu_en,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data
);

  logic signed [ACC_W-1:0] shifted;
  wide_t                   relu_val;
  logic [DATA_W-1:0]       result;

  always_comb begin
    shifted  = cap_sum >>> FRAC_BITS;
    relu_val = wide_t'(shifted);
    if (relu_en && shifted[ACC_W-1]) relu_val = '0;
    result   = DATA_W'(narrow_sat(relu_val, DATA_W));
  end

  // A flush drops a pending write but keeps the last written word visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (flush) begin
      wr_en <= 1'b0;
    end else begin
      wr_en <= cap;
      if (cap) begin
        wr_addr <= cap_addr;
        wr_data <= result;
      end
    end
  end

endmodule

// File: rtl/neuron_mac_unit.sv
// Signed MAC downstream of the layer address generator; one neuron-memory write per neuron.
module neuron_mac_unit
  import nn_pkg::*;
#(
  parameter int unsigned DATA_W    = NN_DATA_W,
  parameter int unsigned ACC_W     = NN_ACC_W,
  parameter int unsigned FRAC_BITS = NN_FRAC_BITS,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              run,
  input  logic              neuron_finished,
  input  logic [7:0]        neuro_write_addr,
  input  logic [DATA_W-1:0] weight_data,
  input  logic [DATA_W-1:0] neuro_data,
  input  logic              relu_en,
  output logic              wr_en,
  output logic [7:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              acc_ovf
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned DL_AW  = RD_LAT * ADDR_W;

  logic [RD_LAT-1:0]             dl_v;
  logic [RD_LAT-1:0]             dl_last;
  logic [RD_LAT-1:0][ADDR_W-1:0] dl_addr;
  logic                          term_v;
  logic                          term_last;
  logic [ADDR_W-1:0]             term_addr;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  wide_t                    sum_wide;
  logic                     sat_hit;

  // Address-side flags delayed to line up with the memory read data.
  always_ff @(posedge clk) begin
    if (!reset || start) dl_v <= '0;
    else                 dl_v <= RD_LAT'({dl_v, run});
  end

  always_ff @(posedge clk) begin
    dl_last <= RD_LAT'({dl_last, neuron_finished});
    dl_addr <= DL_AW'({dl_addr, neuro_write_addr});
  end

  assign term_v    = dl_v[RD_LAT-1];
  assign term_last = dl_last[RD_LAT-1];
  assign term_addr = dl_addr[RD_LAT-1];

  assign prod = $signed(weight_data) * $signed(neuro_data);

  always_comb begin
    sat_hit  = 1'b0;
    sum_wide = sat_add(wide_t'(acc), wide_t'(prod), ACC_W, sat_hit);
    sum      = ACC_W'(sum_wide);
  end

  // Last term of a neuron hands the sum to the output stage and restarts from zero.
  always_ff @(posedge clk) begin
    if (!reset || start) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (term_v) begin
      acc <= term_last ? '0 : sum;
      if (sat_hit) acc_ovf <= 1'b1;
    end
  end

  neuron_out_stage #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .FRAC_BITS(FRAC_BITS),
    .ADDR_W   (ADDR_W)
  ) u_out (
    .clk     (clk),
    .reset   (reset),
    .flush   (start),
    .cap     (term_v && term_last),
    .cap_sum (sum),
    .cap_addr(term_addr),
    .relu_en (relu_en),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  assign busy = (|dl_v) | (acc != '0) | wr_en;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Directed bench: default unit, 16-bit-accumulator unit and RD_LAT=2 unit behind a memory model.
module tb_neuron_mac_unit;

  logic clk;
  logic reset, start, run, fin, relu;
  logic [7:0] waddr, w_in, n_in;
  logic [7:0] w_d1, n_d1, w_d2, n_d2;

  logic a_wr_en, a_busy, a_ovf;
  logic [7:0] a_wr_addr, a_wr_data;
  logic b_wr_en, b_busy, b_ovf;
  logic [7:0] b_wr_addr, b_wr_data;
  logic c_wr_en, c_busy, c_ovf;
  logic [7:0] c_wr_addr, c_wr_data;

  logic sel_b;
  logic s_wr_en, s_busy, s_ovf;
  logic [7:0] s_wr_addr, s_wr_data;

  int checks = 0;
  int passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data returns one or two cycles after its address.
  always @(posedge clk) begin
    w_d1 <= w_in;
    n_d1 <= n_in;
    w_d2 <= w_d1;
    n_d2 <= n_d1;
  end

  neuron_mac_unit u_a (
    .clk(clk), .reset(reset), .start(start), .run(run), .neuron_finished(fin),
    .neuro_write_addr(waddr), .weight_data(w_d1), .neuro_data(n_d1), .relu_en(relu),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .busy(a_busy), .acc_ovf(a_ovf)
  );

  neuron_mac_unit #(.ACC_W(16)) u_b (
    .clk(clk), .reset(reset), .start(start), .run(run), .neuron_finished(fin),
    .neuro_write_addr(waddr), .weight_data(w_d1), .neuro_data(n_d1), .relu_en(relu),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .busy(b_busy), .acc_ovf(b_ovf)
  );

  neuron_mac_unit #(.RD_LAT(2)) u_c (
    .clk(clk), .reset(reset), .start(start), .run(run), .neuron_finished(fin),
    .neuro_write_addr(waddr), .weight_data(w_d2), .neuro_data(n_d2), .relu_en(relu),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .busy(c_busy), .acc_ovf(c_ovf)
  );

  always_comb begin
    s_wr_en   = sel_b ? b_wr_en   : a_wr_en;
    s_busy    = sel_b ? b_busy    : a_busy;
    s_ovf     = sel_b ? b_ovf     : a_ovf;
    s_wr_addr = sel_b ? b_wr_addr : a_wr_addr;
    s_wr_data = sel_b ? b_wr_data : a_wr_data;
  end

  typedef struct {
    int         nt;
    logic       sel;
    logic       relu;
    logic [7:0] addr;
    logic [7:0] w0, w1, w2;
    logic [7:0] n0, n1, n2;
    logic [7:0] exp_d;
    logic       exp_o;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic l, input logic [7:0] a,
                       input logic [7:0] w, input logic [7:0] n);
    @(negedge clk);
    start = 1'b0;
    run   = r;
    fin   = l;
    waddr = a;
    w_in  = w;
    n_in  = n;
  endtask

  function automatic logic [7:0] pick3(input int t, input logic [7:0] x0,
                                       input logic [7:0] x1, input logic [7:0] x2);
    if (t == 0) return x0;
    if (t == 1) return x1;
    return x2;
  endfunction

  initial begin
    int         lat, nw, i1, i2;
    logic [7:0] got_d, got_a, d1, a1, d2, a2;
    logic       got_o;

    reset = 1'b0; start = 1'b0; run = 1'b0; fin = 1'b0; relu = 1'b0;
    waddr = '0; w_in = '0; n_in = '0; sel_b = 1'b0;

    vecs[0] = '{3, 1'b0, 1'b0, 8'h40, 8'd16, 8'd16, 8'd16, 8'd16, 8'd32, 8'd48, 8'd96, 1'b0};
    vecs[1] = '{1, 1'b0, 1'b0, 8'h41, 8'hF0, 8'h00, 8'h00, 8'd32, 8'h00, 8'h00, 8'hE0, 1'b0};
    vecs[2] = '{1, 1'b0, 1'b1, 8'h41, 8'hF0, 8'h00, 8'h00, 8'd32, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{2, 1'b0, 1'b0, 8'h42, 8'h7F, 8'h7F, 8'h00, 8'h7F, 8'h7F, 8'h00, 8'h7F, 1'b0};
    vecs[4] = '{3, 1'b1, 1'b0, 8'h43, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1};
    vecs[5] = '{1, 1'b0, 1'b0, 8'h44, 8'h80, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h80, 1'b0};
    vecs[6] = '{1, 1'b0, 1'b0, 8'h45, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[7] = '{2, 1'b1, 1'b1, 8'h46, 8'd16, 8'd16, 8'h00, 8'd16, 8'd16, 8'h00, 8'h20, 1'b0};
    vecs[8] = '{1, 1'b0, 1'b1, 8'h47, 8'h80, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 1'b0};

    // Reset held with start also asserted: reset wins and everything reads zero.
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en",   32'(a_wr_en),   32'd0);
    chk("rst_wr_addr", 32'(a_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(a_wr_data), 32'd0);
    chk("rst_acc_ovf", 32'(a_ovf),     32'd0);
    chk("rst_busy_a",  32'(a_busy),    32'd0);
    chk("rst_busy_b",  32'(b_busy),    32'd0);
    chk("rst_busy_c",  32'(c_busy),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;

    foreach (vecs[k]) begin
      sel_b = vecs[k].sel;
      relu  = vecs[k].relu;
      @(negedge clk);
      start = 1'b1;
      run   = 1'b0;
      fin   = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ovf_after_start", k), 32'(s_ovf), 32'd0);
      lat = -1; nw = 0; got_d = '0; got_a = '0; got_o = 1'b0;
      for (int i = 0; i < vecs[k].nt + 5; i++) begin
        if (i < vecs[k].nt)
          drive(1'b1, (i == vecs[k].nt - 1), vecs[k].addr,
                pick3(i, vecs[k].w0, vecs[k].w1, vecs[k].w2),
                pick3(i, vecs[k].n0, vecs[k].n1, vecs[k].n2));
        else
          drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        if (s_wr_en) begin
          nw++;
          if (lat < 0) begin
            lat   = (i + 1) - (vecs[k].nt - 1);
            got_d = s_wr_data;
            got_a = s_wr_addr;
            got_o = s_ovf;
          end
        end
      end
      chk($sformatf("v%0d_latency", k), 32'(lat),   32'd2);
      chk($sformatf("v%0d_writes", k),  32'(nw),    32'd1);
      chk($sformatf("v%0d_wr_data", k), 32'(got_d), 32'(vecs[k].exp_d));
      chk($sformatf("v%0d_wr_addr", k), 32'(got_a), 32'(vecs[k].addr));
      chk($sformatf("v%0d_acc_ovf", k), 32'(got_o), 32'(vecs[k].exp_o));
      chk($sformatf("v%0d_idle_busy", k), 32'(s_busy), 32'd0);
    end

    // Back-to-back two-input neurons through the RD_LAT=2 unit.
    relu = 1'b0;
    @(negedge clk);
    start = 1'b1;
    run   = 1'b0;
    nw = 0; i1 = -1; i2 = -1; d1 = '0; a1 = '0; d2 = '0; a2 = '0;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: drive(1'b1, 1'b0, 8'h10, 8'd16, 8'd16);
        1: drive(1'b1, 1'b1, 8'h10, 8'd16, 8'd16);
        2: drive(1'b1, 1'b0, 8'h11, 8'd16, 8'hF0);
        3: drive(1'b1, 1'b1, 8'h11, 8'd16, 8'hF0);
        default: drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      endcase
      @(posedge clk);
      #1;
      if (c_wr_en) begin
        nw++;
        if (nw == 1) begin i1 = i + 1; d1 = c_wr_data; a1 = c_wr_addr; end
        if (nw == 2) begin i2 = i + 1; d2 = c_wr_data; a2 = c_wr_addr; end
      end
    end
    chk("b2b_writes",    32'(nw), 32'd2);
    chk("b2b_a_cycle",   32'(i1), 32'd4);
    chk("b2b_b_cycle",   32'(i2), 32'd6);
    chk("b2b_a_data",    32'(d1), 32'h20);
    chk("b2b_a_addr",    32'(a1), 32'h10);
    chk("b2b_b_data",    32'(d2), 32'hE0);
    chk("b2b_b_addr",    32'(a2), 32'h11);
    chk("b2b_idle_busy", 32'(c_busy), 32'd0);

    // Abort by start: prior write of 16 at 0x51 must stay visible.
    sel_b = 1'b0;
    drive(1'b1, 1'b1, 8'h51, 8'd16, 8'd16);
    repeat (4) drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h52, 8'd16, 8'd16);
    @(posedge clk);
    #1;
    chk("start_abort_busy_before", 32'(a_busy), 32'd1);
    @(negedge clk);
    start = 1'b1; run = 1'b1; fin = 1'b1; waddr = 8'h53;
    @(posedge clk);
    #1;
    chk("start_abort_busy",    32'(a_busy),    32'd0);
    chk("start_abort_acc",     32'(u_a.acc),   32'd0);
    chk("start_abort_wr_data", 32'(a_wr_data), 32'h10);
    chk("start_abort_wr_addr", 32'(a_wr_addr), 32'h51);
    nw = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      @(posedge clk);
      #1;
      if (a_wr_en) nw++;
    end
    chk("start_abort_no_write", 32'(nw), 32'd0);

    // Abort by reset (with start also high): write registers clear too.
    drive(1'b1, 1'b0, 8'h54, 8'd16, 8'd16);
    @(posedge clk);
    #1;
    chk("rst_abort_busy_before", 32'(a_busy), 32'd1);
    @(negedge clk);
    reset = 1'b0; start = 1'b1; run = 1'b1; fin = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_abort_busy",    32'(a_busy),    32'd0);
    chk("rst_abort_acc",     32'(u_a.acc),   32'd0);
    chk("rst_abort_wr_en",   32'(a_wr_en),   32'd0);
    chk("rst_abort_wr_data", 32'(a_wr_data), 32'd0);
    chk("rst_abort_wr_addr", 32'(a_wr_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    nw = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      @(posedge clk);
      #1;
      if (a_wr_en) nw++;
    end
    chk("rst_abort_no_write", 32'(nw), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/neuron_mac_unit.md
Name: neuron_mac_unit

Overview:
Datapath stage directly downstream of the layer address generator. Consumes the weight and neuron words that memory returns for the generator's read addresses and accumulates one signed multiply per cycle. On each neuron boundary it applies scaling, optional ReLU and saturation. It then emits one write (data plus write address) into the neuron memory at the generator's write address.

Parameters:
DATA_W, 8, width of weight, neuron and result words (signed two's complement, fixed point)
ACC_W, 24, accumulator width (signed); must be >= 2*DATA_W
FRAC_BITS, 4, fractional bits of the fixed-point format; product is shifted right by this amount
RD_LAT, 1, read latency of the weight/neuron memories in cycles (>= 1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
start  in  1  layer start; same cycle as the generator's base/Nk load strobe; flushes the unit
run  in  1  generator is issuing valid addresses this cycle
neuron_finished  in  1  generator flag: current address cycle is the last input of the current neuron
neuro_write_addr  in  8  generator write address for the current neuron (address-cycle aligned)
weight_data  in  DATA_W  memory read data; valid RD_LAT cycles after its address
neuro_data  in  DATA_W  memory read data; valid RD_LAT cycles after its address
relu_en  in  1  1 = clamp negative results to 0
wr_en  out  1  one-cycle write strobe for neuron memory
wr_addr  out  8  write address, held with wr_data
wr_data  out  DATA_W  saturated result
busy  out  1  any valid term in the pipeline or accumulator non-empty
acc_ovf  out  1  sticky: accumulator saturated since last start/reset

Behaviour:
- Reset (reset==0 at clk edge): acc=0; delay-line valid bits=0; wr_en=0; wr_addr=0; wr_data=0; acc_ovf=0; busy=0. Reset dominates start.
- start==1 (reset high): same clearing as reset, except wr_addr and wr_data hold their values. In-flight terms and any pending write are dropped. run during a start cycle is ignored.
- Delay line: {run, neuron_finished, neuro_write_addr} is delayed RD_LAT cycles so it aligns with the returned data. The aligned flags are term_v, term_last, term_addr.
- Product: signed weight_data*neuro_data, 2*DATA_W bits, sign-extended to ACC_W.
- Accumulate (cycle term_v==1):
  - sum = acc + product, saturating at signed ACC_W limits.
  - On saturation, acc_ovf is set to 1 and stays set.
  - If term_last==0: acc <= sum.
  - If term_last==1: acc <= 0, and sum is captured into the output stage with term_addr.
- term_v==0: acc holds; no output activity.
- Output stage (one register, cycle after capture):
  - r = sum >>> FRAC_BITS (arithmetic shift, truncation toward negative infinity).
  - If relu_en and r<0, r=0.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - wr_data<=r, wr_addr<=term_addr, wr_en<=1 for exactly one cycle.
- Latency: from the address cycle carrying neuron_finished to wr_en high is RD_LAT+1 cycles.
- Throughput: one term per cycle, back-to-back neurons with no bubble. When term_last is followed immediately by the next neuron's first term, that term accumulates onto 0.
- relu_en is sampled in the capture cycle.
- Single-input neurons (every term_last==1) produce one write per cycle.
- busy = OR of delay-line valid bits | (acc!=0) | wr_en.
- Gaps in run (term_v==0) mid-neuron are legal; the accumulator holds.

Decomposition:
- Shared package nn_pkg: DATA_W/ACC_W/FRAC_BITS defaults, signed data/acc typedefs, and the saturating-add and narrow-saturate functions. The address generator and future activation stages reuse these.
- One sub-module: neuron_out_stage, containing the shift, ReLU, saturate and output register.
- The delay line stays inline.

Test Plan (defaults unless stated, RD_LAT=1):
- Basic dot product: 3 inputs, weights {16,16,16}, neurons {16,32,48}, last on 3rd, write addr 0x40 -> wr_en one cycle, 2 cycles after last address; wr_data=96, wr_addr=0x40.
- ReLU:
  - weight -16, neuron 32, single input -> relu_en=0 gives wr_data=-32 (0xE0).
  - relu_en=1 gives wr_data=0.
- Output saturation: 2 inputs, weights {127,127}, neurons {127,127} -> sum 32258, >>4=2016, wr_data=127, acc_ovf=0.
- Accumulator saturation (ACC_W=16): 3 inputs of 127*127 -> acc clamps at 32767, acc_ovf=1, wr_data=127.
  - After start: acc_ovf=0.
- Back-to-back neurons with RD_LAT=2, 2 inputs each:
  - Neuron A: {16*16, 16*16}, addr 0x10 -> writes 32 at 0x10.
  - Neuron B: {16*-16, 16*-16}, addr 0x11 -> writes -32 at 0x11.
  - Writes on consecutive pair cycles; no cross-contamination.
- Mid-neuron abort:
  - reset=0 after 1 of 3 terms -> no wr_en; acc=0; busy=0 next cycle.
  - Repeat using start=1 instead -> same result, wr_data keeps its previous value.
